// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: FSM state codes, grant codes and
// the fixed-priority grant decision.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StStrobe  = 2'd2,
    StCapture = 2'd3
  } state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntLs = 1'b1
  } gnt_e;

  // Data port wins unless the fetch port is waiting and has hit its starvation limit.
  function automatic gnt_e pick_grant(input logic if_req, input logic ls_req,
                                      input logic at_limit);
    return (ls_req && !(if_req && at_limit)) ? GntLs : GntIf;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data arbitration with a saturating starvation counter that forces a
// fetch grant after StarveLimit consecutive data grants.
module mem_arb_prio
  import mem_pkg::*;
#(
  parameter int unsigned StarveLimit = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic grant_en_i,
  output gnt_e gnt_o
);

  localparam int unsigned CntW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] Limit = CntW'(StarveLimit);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit;

  assign at_limit = (cnt_q == Limit);
  assign gnt_o    = pick_grant(if_req_i, ls_req_i, at_limit);

  // Only a data grant that bypasses a waiting fetch counts towards starvation.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_en_i) begin
      if ((gnt_o == GntLs) && if_req_i) begin
        cnt_d = at_limit ? cnt_q : cnt_q + CntW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter driving a single strobed memory with a
// fixed four-cycle IDLE-SETUP-STROBE-CAPTURE transaction.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_ACK,
  input  logic          LS_REQ,
  input  logic          LS_WE,
  input  logic [AW-1:0] LS_ADDR,
  input  logic [DW-1:0] LS_WDATA,
  output logic          LS_ACK,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_DIN,
  output logic          MEM_WE,
  output logic          MEM_CLK,
  input  logic [DW-1:0] MEM_OUT,
  output logic          BUSY,
  output logic [1:0]    ESTADO
);

  state_e        state_q;
  gnt_e          gnt_q, gnt_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] rdata_q;
  logic          we_q;
  logic          start;

  assign start = (state_q == StIdle) && (IF_REQ || LS_REQ);

  mem_arb_prio #(
    .StarveLimit(STARVE_LIMIT)
  ) u_prio (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .if_req_i  (IF_REQ),
    .ls_req_i  (LS_REQ),
    .grant_en_i(start),
    .gnt_o     (gnt_d)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      gnt_q   <= GntIf;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSetup;
            gnt_q   <= gnt_d;
            if (gnt_d == GntLs) begin
              addr_q <= LS_ADDR;
              din_q  <= LS_WDATA;
              we_q   <= LS_WE;
            end else begin
              addr_q <= IF_ADDR;
              we_q   <= 1'b0;
            end
          end
        end
        StSetup: state_q <= StStrobe;
        StStrobe: begin
          state_q <= StCapture;
          // Latched on entry to CAPTURE so read data is valid alongside ACK.
          if (!we_q) rdata_q <= MEM_OUT;
        end
        StCapture: begin
          state_q <= StIdle;
          we_q    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MEM_ADDR = addr_q;
  assign MEM_DIN  = din_q;
  assign MEM_WE   = we_q;
  assign MEM_CLK  = (state_q == StStrobe);
  assign RDATA    = rdata_q;
  assign BUSY     = (state_q != StIdle);
  assign ESTADO   = state_q;
  assign IF_ACK   = (state_q == StCapture) && (gnt_q == GntIf);
  assign LS_ACK   = (state_q == StCapture) && (gnt_q == GntLs);

  ack_exclusive_a: assert property (@(posedge CLK) disable iff (!RST) !(IF_ACK && LS_ACK));
  we_from_ls_a:    assert property (@(posedge CLK) disable iff (!RST) MEM_WE |-> gnt_q == GntLs);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned Limit = 3;

  logic        CLK, RST;
  logic        IF_REQ, LS_REQ, LS_WE;
  logic [15:0] IF_ADDR, LS_ADDR, MEM_ADDR;
  logic [31:0] LS_WDATA, MEM_DIN, MEM_OUT, RDATA;
  logic        IF_ACK, LS_ACK, MEM_WE, MEM_CLK, BUSY;
  logic [1:0]  ESTADO;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .AW          (16),
    .DW          (32),
    .STARVE_LIMIT(Limit)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IF_REQ  (IF_REQ),
    .IF_ADDR (IF_ADDR),
    .IF_ACK  (IF_ACK),
    .LS_REQ  (LS_REQ),
    .LS_WE   (LS_WE),
    .LS_ADDR (LS_ADDR),
    .LS_WDATA(LS_WDATA),
    .LS_ACK  (LS_ACK),
    .RDATA   (RDATA),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DIN (MEM_DIN),
    .MEM_WE  (MEM_WE),
    .MEM_CLK (MEM_CLK),
    .MEM_OUT (MEM_OUT),
    .BUSY    (BUSY),
    .ESTADO  (ESTADO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
  endfunction

  // Behavioural memory: writes on the rising strobe, asynchronous read.
  logic [31:0]  dev_mem [256];
  logic [255:0] dev_wr = '0;
  always @(posedge MEM_CLK) begin
    if (MEM_WE) begin
      dev_mem[MEM_ADDR[7:0]] <= MEM_DIN;
      dev_wr[MEM_ADDR[7:0]]  <= 1'b1;
    end
  end
  assign MEM_OUT = dev_wr[MEM_ADDR[7:0]] ? dev_mem[MEM_ADDR[7:0]] : init_val(MEM_ADDR);

  logic [31:0] ref_mem [logic [15:0]];
  function automatic logic [31:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    RST = 1'b0; IF_REQ = 1'b0; LS_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  // Waits (bounded) for an ACK, recording what the memory side saw meanwhile.
  task automatic run_txn(output int lat, output int strobes, output bit if_ack,
                         output bit ls_ack, output bit we_seen, output logic [15:0] st_addr,
                         output logic [31:0] st_din, output logic [31:0] rd);
    lat = 0; strobes = 0; if_ack = 0; ls_ack = 0; we_seen = 0;
    st_addr = '0; st_din = '0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (MEM_WE === 1'b1) we_seen = 1;
      if (MEM_CLK === 1'b1) begin
        strobes++; st_addr = MEM_ADDR; st_din = MEM_DIN;
      end
      if (IF_ACK === 1'b1 || LS_ACK === 1'b1) begin
        lat = c; if_ack = IF_ACK; ls_ack = LS_ACK; rd = RDATA;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({MEM_CLK, MEM_WE, IF_ACK, LS_ACK, BUSY, ESTADO} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {MEM_CLK, MEM_WE, IF_ACK, LS_ACK, BUSY, ESTADO});
    end
    checks++;
    if (MEM_ADDR !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", MEM_ADDR); end
    checks++;
    if (MEM_DIN !== 32'h0) begin errors++; $display("FAIL reset_din: got %h want 0", MEM_DIN); end
    checks++;
    if (RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    IF_REQ = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({BUSY, ESTADO} !== 3'b0) begin
      errors++; $display("FAIL reset_hold: busy/estado got %b want 000", {BUSY, ESTADO});
    end
    IF_REQ = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_single_fetch();
    int lat, strobes; bit ia, la, we; logic [15:0] sa; logic [31:0] sd, rd;
    IF_ADDR = 16'h0010; IF_REQ = 1'b1;
    run_txn(lat, strobes, ia, la, we, sa, sd, rd);
    IF_REQ = 1'b0;
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL fetch_latency: got %0d want 3", lat); end
    checks++;
    if ({ia, la} !== 2'b10) begin errors++; $display("FAIL fetch_ack: got %b want 10", {ia, la}); end
    checks++;
    if (strobes !== 1) begin errors++; $display("FAIL fetch_strobes: got %0d want 1", strobes); end
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b want 0", we); end
    checks++;
    if (sa !== 16'h0010) begin errors++; $display("FAIL fetch_addr: got %h want 0010", sa); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", rd); end
    @(posedge CLK); #1;
    checks++;
    if ({BUSY, IF_ACK, ESTADO} !== 4'b0) begin
      errors++; $display("FAIL fetch_idle: busy/ack/estado got %b want 0000", {BUSY, IF_ACK, ESTADO});
    end
  endtask

  task automatic test_write_read();
    int lat, strobes; bit ia, la, we; logic [15:0] sa; logic [31:0] sd, rd, rd0;
    rd0 = RDATA;
    LS_ADDR = 16'h0020; LS_WDATA = 32'h12345678; LS_WE = 1'b1; LS_REQ = 1'b1;
    run_txn(lat, strobes, ia, la, we, sa, sd, rd);
    LS_REQ = 1'b0;
    ref_mem[16'h0020] = 32'h12345678;
    checks++;
    if (lat !== 3 || {ia, la} !== 2'b01) begin
      errors++; $display("FAIL wr_ack: lat %0d ack %b want 3 01", lat, {ia, la});
    end
    checks++;
    if (we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", we); end
    checks++;
    if ({sa, sd} !== {16'h0020, 32'h12345678}) begin
      errors++; $display("FAIL wr_bus: got %h/%h want 0020/12345678", sa, sd);
    end
    checks++;
    if (rd !== rd0) begin errors++; $display("FAIL wr_rdata_kept: got %h want %h", rd, rd0); end
    @(posedge CLK); #1;
    LS_WE = 1'b0; LS_REQ = 1'b1;
    run_txn(lat, strobes, ia, la, we, sa, sd, rd);
    LS_REQ = 1'b0;
    checks++;
    if (lat !== 3 || {ia, la} !== 2'b01) begin
      errors++; $display("FAIL rd_ack: lat %0d ack %b want 3 01", lat, {ia, la});
    end
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", we); end
    checks++;
    if (rd !== ref_read(16'h0020)) begin
      errors++; $display("FAIL rd_data: got %h want %h", rd, ref_read(16'h0020));
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_simultaneous();
    int lat, strobes, starve; bit ia, la, we, exp_ls; logic [15:0] sa, ea; logic [31:0] sd, rd;
    apply_reset();
    starve = 0;
    IF_ADDR = 16'($urandom_range(0, 127));
    LS_ADDR = IF_ADDR + 16'd128;
    LS_WE = 1'b0; IF_REQ = 1'b1; LS_REQ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_ls = (starve != Limit);
      starve = exp_ls ? ((starve == Limit) ? starve : starve + 1) : 0;
      ea = exp_ls ? LS_ADDR : IF_ADDR;
      run_txn(lat, strobes, ia, la, we, sa, sd, rd);
      checks++;
      if ({ia, la} !== {!exp_ls, exp_ls}) begin
        errors++; $display("FAIL sim_grant[%0d]: ack if/ls got %b want %b", k, {ia, la},
                           {!exp_ls, exp_ls});
      end
      checks++;
      if (lat !== ((k == 0) ? 3 : 4)) begin
        errors++; $display("FAIL sim_latency[%0d]: got %0d want %0d", k, lat, (k == 0) ? 3 : 4);
      end
      checks++;
      if (rd !== ref_read(ea)) begin
        errors++; $display("FAIL sim_rdata[%0d]: got %h want %h", k, rd, ref_read(ea));
      end
    end
    IF_REQ = 1'b0; LS_REQ = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat, strobes; bit ia, la, we, seen; logic [15:0] sa; logic [31:0] sd, rd;
    IF_ADDR = 16'h0033; IF_REQ = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if ({MEM_CLK, ESTADO} !== 3'b110) begin
      errors++; $display("FAIL rst_pre_strobe: memclk/estado got %b want 110", {MEM_CLK, ESTADO});
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({MEM_CLK, BUSY, IF_ACK, LS_ACK, ESTADO} !== 6'b0) begin
      errors++; $display("FAIL rst_async: got %b want 0", {MEM_CLK, BUSY, IF_ACK, LS_ACK, ESTADO});
    end
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      if (IF_ACK || LS_ACK || BUSY) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b want 0", seen); end
    RST = 1'b1;
    run_txn(lat, strobes, ia, la, we, sa, sd, rd);
    IF_REQ = 1'b0;
    checks++;
    if (lat !== 3 || {ia, la} !== 2'b10) begin
      errors++; $display("FAIL rst_resume: lat %0d ack %b want 3 10", lat, {ia, la});
    end
    checks++;
    if (rd !== ref_read(16'h0033)) begin
      errors++; $display("FAIL rst_resume_data: got %h want %h", rd, ref_read(16'h0033));
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_early_drop();
    int pulses, ack_cyc; logic [31:0] rd;
    LS_ADDR = 16'h0044; LS_WE = 1'b0; LS_REQ = 1'b1;
    @(posedge CLK); #1;
    LS_REQ = 1'b0;
    pulses = 0; ack_cyc = 0; rd = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge CLK); #1;
      if (LS_ACK === 1'b1) begin
        pulses++; ack_cyc = c; rd = RDATA;
      end
    end
    checks++;
    if (pulses !== 1 || ack_cyc !== 2) begin
      errors++; $display("FAIL drop_ack: pulses %0d at %0d want 1 at 2", pulses, ack_cyc);
    end
    checks++;
    if (rd !== ref_read(16'h0044)) begin
      errors++; $display("FAIL drop_data: got %h want %h", rd, ref_read(16'h0044));
    end
    checks++;
    if ({BUSY, ESTADO} !== 3'b0) begin
      errors++; $display("FAIL drop_idle: busy/estado got %b want 000", {BUSY, ESTADO});
    end
  endtask

  // Transaction-level model: a request seen in idle starts a 4-cycle transaction.
  task automatic test_random();
    int phase, starve; bit g_ls, s_if, s_ls, m_we;
    logic [15:0] m_addr; logic [31:0] m_din, m_rdata;
    apply_reset();
    phase = 0; starve = 0; g_ls = 0; m_we = 0; m_addr = '0; m_din = '0; m_rdata = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge CLK); #1;
      s_if = IF_REQ; s_ls = LS_REQ;
      if (phase == 0) begin
        if (s_if || s_ls) begin
          g_ls = (s_if && s_ls) ? (starve != Limit) : s_ls;
          if (g_ls && s_if) starve = (starve == Limit) ? starve : starve + 1;
          else starve = 0;
          m_addr = g_ls ? LS_ADDR : IF_ADDR;
          m_we = g_ls && LS_WE;
          m_din = LS_WDATA;
          phase = 1;
        end
      end else begin
        phase = (phase + 1) % 4;
      end
      if (phase == 2 && m_we) ref_mem[m_addr] = m_din;
      if (phase == 3 && !m_we) m_rdata = ref_read(m_addr);

      checks++;
      if (ESTADO !== 2'(phase) || BUSY !== (phase != 0) || MEM_CLK !== (phase == 2)) begin
        errors++; $display("FAIL rnd_state[%0d]: estado/busy/memclk %0d/%b/%b want %0d", cyc,
                           ESTADO, BUSY, MEM_CLK, phase);
      end
      checks++;
      if ({IF_ACK, LS_ACK} !== {phase == 3 && !g_ls, phase == 3 && g_ls}) begin
        errors++; $display("FAIL rnd_ack[%0d]: got %b want %b", cyc, {IF_ACK, LS_ACK},
                           {phase == 3 && !g_ls, phase == 3 && g_ls});
      end
      if (phase != 0) begin
        checks++;
        if (MEM_ADDR !== m_addr || MEM_WE !== m_we) begin
          errors++; $display("FAIL rnd_bus[%0d]: addr/we %h/%b want %h/%b", cyc, MEM_ADDR,
                             MEM_WE, m_addr, m_we);
        end
        if (m_we) begin
          checks++;
          if (MEM_DIN !== m_din) begin
            errors++; $display("FAIL rnd_din[%0d]: got %h want %h", cyc, MEM_DIN, m_din);
          end
        end
      end
      checks++;
      if (RDATA !== m_rdata) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, RDATA, m_rdata);
      end

      if (phase == 3) begin
        if (g_ls) LS_REQ = 1'b0;
        else IF_REQ = 1'b0;
      end
      if (!IF_REQ && $urandom_range(0, 2) == 0) begin
        IF_ADDR = 16'($urandom_range(0, 255));
        IF_REQ = 1'b1;
      end
      if (!LS_REQ && $urandom_range(0, 2) == 0) begin
        LS_ADDR = 16'($urandom_range(0, 255));
        LS_WE = 1'($urandom_range(0, 1));
        LS_WDATA = $urandom;
        LS_REQ = 1'b1;
      end
    end
    IF_REQ = 1'b0; LS_REQ = 1'b0;
  endtask

  initial begin
    RST = 1'b1; IF_REQ = 1'b0; LS_REQ = 1'b0; LS_WE = 1'b0;
    IF_ADDR = '0; LS_ADDR = '0; LS_WDATA = '0;
    test_reset();
    test_single_fetch();
    test_write_read();
    test_simultaneous();
    test_reset_mid_op();
    test_early_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
